// File: rtl/poker_types.sv
// Shared poker datatypes: cards, deal commands, sequencer state encoding.
// Latency: n/a (types, constants and one combinational helper).
// Backpressure: n/a.
package poker_types;

  typedef enum logic [3:0] {
    RANK_ACE = 4'd0, RANK_2, RANK_3, RANK_4, RANK_5, RANK_6, RANK_7,
    RANK_8, RANK_9, RANK_10, RANK_JACK, RANK_QUEEN, RANK_KING
  } rank_t;

  typedef enum logic [1:0] {
    SUIT_SPADES = 2'd0, SUIT_HEARTS, SUIT_DIAMONDS, SUIT_CLUBS
  } suit_t;

  typedef struct packed {
    rank_t rank;
    suit_t suit;
  } card_t;

  typedef enum logic [1:0] {
    DEAL_HOLE  = 2'd0,
    DEAL_FLOP  = 2'd1,
    DEAL_TURN  = 2'd2,
    DEAL_RIVER = 2'd3
  } deal_cmd_t;

  typedef logic [2:0] deal_state_t;
  localparam deal_state_t ST_IDLE   = 3'd0;
  localparam deal_state_t ST_DRAW   = 3'd1;
  localparam deal_state_t ST_WRITE  = 3'd2;
  localparam deal_state_t ST_FINISH = 3'd3;
  localparam deal_state_t ST_ERR    = 3'd4;

  localparam int BOARD_SLOTS = 5;

  // (dealer + 1) mod n for n in 2..8; dealer may be >= n, so reduce by
  // repeated subtraction (at most four steps for these ranges).
  function automatic logic [2:0] first_seat(input logic [2:0] dealer,
                                            input logic [3:0] n);
    logic [3:0] a;
    a = {1'b0, dealer} + 4'd1;
    for (int i = 0; i < 4; i++) begin
      if (a >= n) a = a - n;
    end
    return a[2:0];
  endfunction

endpackage

// File: rtl/deal_sequencer.sv
// Sequences deck draws for one hand: hole cards round-robin, then burn+flop/turn/river.
// Latency: first draw_card 1 cycle after accept; write strobe 1 cycle after card_valid; done 1 cycle after last write.
// Backpressure: cmd_ready low while busy; draw_card held until card_valid or timeout.
// Ports: clk/reset_n; command side cmd_valid/cmd/cmd_ready with player_count/dealer_pos
// sampled at accept; deck side deck_ready/draw_card/card_valid/top_card; write side
// player_en/set_card/hole_slot, board_wr/board_idx, card_out; status busy/done/err.
module deal_sequencer
  import poker_types::*;
#(
  parameter int MAX_PLAYERS  = 8,
  parameter bit BURN_EN      = 1'b1,
  parameter int DRAW_TIMEOUT = 255
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [2:0]             player_count,
  input  logic [2:0]             dealer_pos,
  input  logic                   cmd_valid,
  input  deal_cmd_t              cmd,
  output logic                   cmd_ready,
  input  logic                   deck_ready,
  output logic                   draw_card,
  input  logic                   card_valid,
  input  card_t                  top_card,
  output logic [MAX_PLAYERS-1:0] player_en,
  output logic                   set_card,
  output logic                   hole_slot,
  output logic                   board_wr,
  output logic [2:0]             board_idx,
  output card_t                  card_out,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);

  localparam int          TW    = $clog2(DRAW_TIMEOUT + 1);
  localparam logic [TW-1:0] TLAST = TW'(DRAW_TIMEOUT - 1);
  localparam logic [4:0]  BURN_N = {4'd0, BURN_EN};
  localparam logic [2:0]  IDX_TURN  = 3'(BOARD_SLOTS - 2);
  localparam logic [2:0]  IDX_RIVER = 3'(BOARD_SLOTS - 1);

  deal_state_t   state_q, state_d;
  deal_cmd_t     cmd_q, cmd_d;
  logic [3:0]    n_q, n_d;        // seated players, 2..8
  logic [2:0]    seat_q, seat_d;
  logic [4:0]    draw_q, draw_d;  // draws completed in this command
  logic [TW-1:0] timer_q, timer_d;
  card_t         card_q, card_d;

  logic [4:0] total;
  logic       last_draw, is_burn, slot, wr_player, wr_board, accept;
  logic [2:0] pc_eff;
  logic [3:0] n_new;
  logic [2:0] idx;

  always_comb begin
    total = 5'd0;
    idx   = 3'd0;
    case (cmd_q)
      DEAL_HOLE:  total = {n_q, 1'b0};
      DEAL_FLOP:  begin total = 5'd3 + BURN_N; idx = draw_q[2:0] - BURN_N[2:0]; end
      DEAL_TURN:  begin total = 5'd1 + BURN_N; idx = IDX_TURN; end
      default:    begin total = 5'd1 + BURN_N; idx = IDX_RIVER; end
    endcase
  end

  assign last_draw = (draw_q == total - 5'd1);
  assign is_burn   = BURN_EN && (cmd_q != DEAL_HOLE) && (draw_q == 5'd0);
  // Second lap of the table starts once every seat has one card.
  assign slot      = (draw_q >= {1'b0, n_q});
  assign wr_player = (state_q == ST_WRITE) && (cmd_q == DEAL_HOLE);
  assign wr_board  = (state_q == ST_WRITE) && (cmd_q != DEAL_HOLE) && !is_burn;

  // Not busy in FINISH/ERR, so a new command may be taken the same cycle done/err pulses.
  assign busy      = (state_q == ST_DRAW) || (state_q == ST_WRITE);
  assign cmd_ready = !busy;
  assign accept    = cmd_valid && cmd_ready;
  assign draw_card = (state_q == ST_DRAW);
  assign done      = (state_q == ST_FINISH);
  assign err       = (state_q == ST_ERR);
  assign set_card  = wr_player;
  assign player_en = wr_player ? (MAX_PLAYERS'(1) << seat_q) : '0;
  assign hole_slot = wr_player && slot;
  assign board_wr  = wr_board;
  assign board_idx = wr_board ? idx : 3'd0;
  assign card_out  = card_q;

  assign pc_eff = (player_count == 3'd0) ? 3'd1 : player_count;
  assign n_new  = {1'b0, pc_eff} + 4'd1;

  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    n_d     = n_q;
    seat_d  = seat_q;
    draw_d  = draw_q;
    timer_d = timer_q;
    card_d  = card_q;
    case (state_q)
      ST_DRAW: begin
        if (card_valid) begin
          card_d  = top_card;
          state_d = ST_WRITE;
        end else if (timer_q == TLAST) begin
          state_d = ST_ERR;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      ST_WRITE: begin
        draw_d = draw_q + 5'd1;
        if (cmd_q == DEAL_HOLE)
          seat_d = ({1'b0, seat_q} == n_q - 4'd1) ? 3'd0 : seat_q + 3'd1;
        if (last_draw) begin
          state_d = ST_FINISH;
        end else begin
          state_d = ST_DRAW;
          timer_d = '0;
        end
      end
      default: begin  // IDLE, FINISH, ERR
        state_d = ST_IDLE;
        if (accept) begin
          cmd_d   = cmd;
          n_d     = n_new;
          seat_d  = first_seat(dealer_pos, n_new);
          draw_d  = 5'd0;
          timer_d = '0;
          state_d = deck_ready ? ST_DRAW : ST_ERR;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cmd_q   <= DEAL_HOLE;
      n_q     <= 4'd0;
      seat_q  <= 3'd0;
      draw_q  <= 5'd0;
      timer_q <= '0;
      card_q  <= '{rank: RANK_ACE, suit: SUIT_SPADES};
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      n_q     <= n_d;
      seat_q  <= seat_d;
      draw_q  <= draw_d;
      timer_q <= timer_d;
      card_q  <= card_d;
    end
  end

endmodule

// File: tb/tb_deal_sequencer.sv
module tb_deal_sequencer;
  import poker_types::*;

  localparam int BURN = 1;

  typedef struct packed {
    logic       brd;
    logic [2:0] seat;
    logic       slot;
    logic [2:0] idx;
    logic [5:0] card;
  } rec_t;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [2:0] player_count = 3'd0;
  logic [2:0] dealer_pos = 3'd0;
  logic       cmd_valid = 1'b0;
  deal_cmd_t  cmd = DEAL_HOLE;
  logic       cmd_ready;
  logic       deck_ready = 1'b1;
  logic       draw_card;
  logic       card_valid = 1'b0;
  card_t      top_card = '{rank: RANK_ACE, suit: SUIT_SPADES};
  logic [7:0] player_en;
  logic       set_card, hole_slot, board_wr, busy, done, err;
  logic [2:0] board_idx;
  card_t      card_out;

  deal_sequencer #(.MAX_PLAYERS(8), .BURN_EN(1'b1), .DRAW_TIMEOUT(255)) dut (
    .clk(clk), .reset_n(reset_n), .player_count(player_count), .dealer_pos(dealer_pos),
    .cmd_valid(cmd_valid), .cmd(cmd), .cmd_ready(cmd_ready), .deck_ready(deck_ready),
    .draw_card(draw_card), .card_valid(card_valid), .top_card(top_card),
    .player_en(player_en), .set_card(set_card), .hole_slot(hole_slot),
    .board_wr(board_wr), .board_idx(board_idx), .card_out(card_out),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_asr = 0, n_fail = 0;

  // Deck responder and write monitor state.
  logic [5:0] drawn[$];
  rec_t       obs_q[$];
  rec_t       mrec;
  logic [5:0] cb;
  int delay = 0, wait_cnt = 0;
  bit respond_off = 0, stray_req = 0;
  int dc_cycles, done_cnt, err_cnt, done_cyc, err_cyc;
  int both_bad, rdy_bad, lat_bad, first_draw_cyc, last_valid_cyc, acc_cyc;

  always @(negedge clk) begin
    if (!reset_n) begin
      card_valid = 1'b0;
      wait_cnt   = 0;
    end else begin
      if (draw_card) begin
        dc_cycles++;
        if (first_draw_cyc < 0) first_draw_cyc = cyc;
      end
      if (done) begin done_cnt++; done_cyc = cyc; end
      if (err)  begin err_cnt++;  err_cyc  = cyc; end
      if (set_card && board_wr) both_bad++;
      if (cmd_ready === busy) rdy_bad++;
      if (set_card || board_wr) begin
        if (cyc != last_valid_cyc + 1) lat_bad++;
        mrec      = '0;
        mrec.brd  = board_wr;
        mrec.card = 6'(card_out);
        if (set_card) begin
          mrec.slot = hole_slot;
          mrec.seat = 3'bxxx;
          if ($onehot(player_en))
            for (int i = 0; i < 8; i++) if (player_en[i]) mrec.seat = 3'(i);
        end else begin
          mrec.idx = board_idx;
        end
        obs_q.push_back(mrec);
      end
      if (card_valid) begin
        card_valid = 1'b0;
      end else if (draw_card && !respond_off) begin
        if (wait_cnt == delay) begin
          cb = {4'($urandom_range(12, 0)), 2'($urandom_range(3, 0))};
          top_card = card_t'(cb);
          card_valid = 1'b1;
          drawn.push_back(cb);
          last_valid_cyc = cyc;
          wait_cnt = 0;
        end else begin
          wait_cnt++;
        end
      end else if (stray_req && !draw_card) begin
        cb = {4'($urandom_range(12, 0)), 2'($urandom_range(3, 0))};
        top_card = card_t'(cb);
        card_valid = 1'b1;
        stray_req = 0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asr++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_obs();
    drawn.delete();
    obs_q.delete();
    dc_cycles = 0; done_cnt = 0; err_cnt = 0; done_cyc = -1; err_cyc = -1;
    both_bad = 0; rdy_bad = 0; lat_bad = 0; first_draw_cyc = -1; last_valid_cyc = -10;
    wait_cnt = 0;
  endtask

  task automatic start_cmd(input int c, input int pc, input int dl, input int dly, input bit rdy);
    step();
    clear_obs();
    delay        = dly;
    player_count = 3'(pc);
    dealer_pos   = 3'(dl);
    cmd          = deal_cmd_t'(2'(c));
    deck_ready   = rdy;
    cmd_valid    = 1'b1;
    acc_cyc      = cyc;
    step();
    // Inputs change after accept; the command in flight must not notice.
    cmd_valid    = 1'b0;
    player_count = 3'($urandom);
    dealer_pos   = 3'($urandom);
    deck_ready   = 1'b1;
  endtask

  task automatic wait_end(input string tag, input int budget);
    for (int i = 0; i < budget && done_cnt == 0 && err_cnt == 0; i++) step();
    chk({tag, "_ended"}, 32'(done_cnt + err_cnt > 0), 32'd1);
  endtask

  // Expected writes derived from the dealing rules and the cards the deck handed out.
  task automatic check_cmd(input string tag, input int c, input int pc, input int dl, input int dly);
    rec_t exp_q[$];
    rec_t e;
    int n, st, nd;
    n  = (pc == 0 ? 1 : pc) + 1;
    st = (dl + 1) % n;
    case (c)
      0: begin
        nd = 2 * n;
        for (int k = 0; k < nd && k < drawn.size(); k++) begin
          e = '0; e.seat = 3'((st + k % n) % n); e.slot = 1'(k / n); e.card = drawn[k];
          exp_q.push_back(e);
        end
      end
      1: begin
        nd = 3 + BURN;
        for (int k = 0; k < 3 && k + BURN < drawn.size(); k++) begin
          e = '0; e.brd = 1'b1; e.idx = 3'(k); e.card = drawn[k + BURN];
          exp_q.push_back(e);
        end
      end
      default: begin
        nd = 1 + BURN;
        if (BURN < drawn.size()) begin
          e = '0; e.brd = 1'b1; e.idx = (c == 2) ? 3'd3 : 3'd4; e.card = drawn[BURN];
          exp_q.push_back(e);
        end
      end
    endcase
    chk({tag, "_done"}, 32'(done_cnt), 32'd1);
    chk({tag, "_err"}, 32'(err_cnt), 32'd0);
    chk({tag, "_draws"}, 32'(drawn.size()), 32'(nd));
    chk({tag, "_nwrites"}, 32'(obs_q.size()), 32'(nd - ((c == 0) ? 0 : BURN)));
    for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++)
      chk($sformatf("%s_wr%0d", tag, k), 32'(obs_q[k]), 32'(exp_q[k]));
    chk({tag, "_draw_hold"}, 32'(dc_cycles), 32'(nd * (dly + 1)));
    chk({tag, "_first_draw"}, 32'(first_draw_cyc), 32'(acc_cyc + 1));
    chk({tag, "_done_time"}, 32'(done_cyc), 32'(last_valid_cyc + 2));
    chk({tag, "_proto"}, 32'(lat_bad + both_bad + rdy_bad), 32'd0);
  endtask

  task automatic run_cmd(input string tag, input int c, input int pc, input int dl, input int dly);
    start_cmd(c, pc, dl, dly, 1'b1);
    wait_end(tag, 800);
    check_cmd(tag, c, pc, dl, dly);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    card_t ace_sp;
    int c, pc, dl, dly;
    ace_sp = '{rank: RANK_ACE, suit: SUIT_SPADES};
    clear_obs();

    // Reset state.
    repeat (3) step();
    chk("rst_outs", {13'd0, cmd_ready, busy, draw_card, set_card, board_wr, done, err,
                     hole_slot, player_en, board_idx}, {13'd0, 1'b1, 18'd0});
    chk("rst_card", 32'(card_out), 32'(ace_sp));
    reset_n = 1'b1;
    step();

    // Directed streets.
    run_cmd("hole4", 0, 3, 2, 1);
    run_cmd("flop", 1, 3, 2, 0);
    run_cmd("turn", 2, 3, 2, 4);
    run_cmd("river", 3, 3, 2, 4);
    run_cmd("hole2", 0, 0, 1, 0);
    run_cmd("hole8_wrap", 0, 7, 7, 2);

    // Random commands against the model.
    for (int i = 0; i < 8; i++) begin
      c   = $urandom_range(3, 0);
      pc  = $urandom_range(7, 0);
      dl  = $urandom_range(7, 0);
      dly = $urandom_range(3, 0);
      run_cmd($sformatf("rnd%0d", i), c, pc, dl, dly);
    end

    // Deck not ready at accept.
    start_cmd(0, 3, 0, 0, 1'b0);
    wait_end("nordy", 20);
    chk("nordy_err", 32'(err_cnt), 32'd1);
    chk("nordy_err_time", 32'(err_cyc), 32'(acc_cyc + 1));
    chk("nordy_draws", 32'(dc_cycles), 32'd0);
    chk("nordy_done", 32'(done_cnt), 32'd0);

    // Draw timeout.
    respond_off = 1;
    start_cmd(1, 1, 0, 0, 1'b1);
    wait_end("tmo", 400);
    chk("tmo_err", 32'(err_cnt), 32'd1);
    chk("tmo_draw_hold", 32'(dc_cycles), 32'd255);
    chk("tmo_err_time", 32'(err_cyc), 32'(acc_cyc + 256));
    chk("tmo_writes", 32'(obs_q.size() + done_cnt), 32'd0);
    respond_off = 0;
    step();
    chk("tmo_idle", {30'd0, cmd_ready, busy}, 32'b10);

    // Command held off while busy.
    start_cmd(0, 2, 5, 0, 1'b1);
    step();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("holdoff_rdy%0d", i), 32'(cmd_ready), 32'd0);
      cmd_valid = 1'b1;
      cmd = DEAL_FLOP;
      step();
    end
    cmd_valid = 1'b0;
    wait_end("holdoff", 200);
    check_cmd("holdoff", 0, 2, 5, 0);
    repeat (4) step();
    chk("holdoff_no_extra", 32'(done_cnt + err_cnt + dc_cycles), 32'(1 + 6));

    // Stray card_valid while idle.
    clear_obs();
    stray_req = 1;
    repeat (4) step();
    chk("stray_ignored", 32'(obs_q.size() + dc_cycles + done_cnt + err_cnt), 32'd0);
    chk("stray_idle", {30'd0, cmd_ready, busy}, 32'b10);

    // Reset in the middle of a hole deal.
    start_cmd(0, 5, 0, 1, 1'b1);
    repeat (6) step();
    reset_n = 1'b0;
    #1;
    chk("midrst_outs", {13'd0, cmd_ready, busy, draw_card, set_card, board_wr, done, err,
                        hole_slot, player_en, board_idx}, {13'd0, 1'b1, 18'd0});
    chk("midrst_card", 32'(card_out), 32'(ace_sp));
    step();
    step();
    reset_n = 1'b1;
    done_cnt = 0;
    repeat (5) step();
    chk("midrst_no_done", 32'(done_cnt), 32'd0);
    chk("midrst_idle", {29'd0, cmd_ready, busy, draw_card}, 32'b100);

    // Sequencer still works after the abort.
    run_cmd("post_rst", 1, 4, 3, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asr, n_fail);
    $finish;
  end

endmodule
